cskip_stream_acc: RTL and testbench

Streaming 32-bit accumulator that sits directly downstream of the 32-bit carry-skip adder. It registers the adder's `sum`/`cout` every accepted beat and feeds the running low word back as the next operand. Carries out of the low word are folded into an upper extension register. Packets of 32-bit words arrive on a valid/ready stream, and one extended-width total per packet leaves on a second valid/ready stream.

---
 rtl/cskip_stream_acc_pkg.sv | 12 +
 rtl/cskip_stream_acc_adder.sv | 31 +++
 rtl/cskip_stream_acc.sv | 90 +++++++++
 tb/tb_cskip_stream_acc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cskip_stream_acc_pkg.sv
// Shared definitions for the streaming carry-skip accumulator: widths and FSM states.
package cskip_stream_acc_pkg;
  localparam int ACC_LO_W  = 32;
  localparam int HI_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/cskip_stream_acc_adder.sv
// 32-bit carry-skip adder, 4-bit ripple blocks; a block whose bits all propagate
// forwards its incoming carry directly to the next block.
module CSkipA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] p;
  logic [31:0] g;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic carry;
    logic blk_cin;
    carry   = 1'b0;
    blk_cin = 1'b0;
    sum     = '0;
    for (int k = 0; k < 8; k++) begin
      blk_cin = carry;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ carry;
        carry      = g[4*k+j] | (p[4*k+j] & carry);
      end
      if (&p[4*k +: 4]) carry = blk_cin;
    end
    cout = carry;
  end
endmodule

// File: rtl/cskip_stream_acc.sv
// Packet accumulator: running low word fed back through the carry-skip adder,
// carries folded into a wrapping upper register, one total per packet.
module cskip_stream_acc
  import cskip_stream_acc_pkg::*;
#(
  parameter int HI_W  = HI_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_LO_W+HI_W-1:0] out_sum,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);
  state_t                state;
  state_t                state_nxt;
  logic                  rdy;
  logic                  accept;
  logic [ACC_LO_W-1:0]   acc_lo;
  logic [HI_W-1:0]       acc_hi;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf;
  logic [ACC_LO_W-1:0]   opa;
  logic [ACC_LO_W-1:0]   sum_lo;
  logic                  cout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept = in_valid && rdy;
  // The first beat of a packet starts from zero rather than the previous total.
  assign opa    = (state == IDLE) ? '0 : acc_lo;

  CSkipA32 u_add (
    .a    (opa),
    .b    (in_data),
    .sum  (sum_lo),
    .cout (cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? HOLD : ACC;
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is registered so it stays low during reset and for the whole HOLD state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy    <= 1'b0;
      acc_lo <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt != HOLD);
      if (accept) begin
        acc_lo <= sum_lo;
        if (state == IDLE) begin
          acc_hi <= '0;
          cnt    <= CNT_W'(1);
          ovf    <= 1'b0;
        end else begin
          acc_hi <= acc_hi + HI_W'(cout);
          cnt    <= sat_inc(cnt);
          ovf    <= ovf | (cout && (&acc_hi));
        end
      end
    end
  end

  assign in_ready  = rdy;
  assign out_valid = (state == HOLD);
  assign out_sum   = {acc_hi, acc_lo};
  assign out_count = cnt;
  assign out_ovf   = ovf;
endmodule

// File: tb/tb_cskip_stream_acc.sv
// Directed + randomized bench for cskip_stream_acc; two instances (HI_W=16 and HI_W=2)
// share the stimulus and are compared against an arithmetic packet-sum model.
module tb_cskip_stream_acc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [47:0] out_sum;
  logic [15:0] out_count;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [33:0] out_sum2;
  logic [15:0] out_count2;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_total;
  int          m_n;
  logic [63:0] e_total;
  int          e_n;
  bit          gaps_on;
  logic [47:0] held_sum;

  cskip_stream_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  cskip_stream_acc #(.HI_W(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat (optionally after random idle gaps) and hold it until accepted.
  task automatic drive_beat(input logic [31:0] data, input bit last);
    int t;
    @(negedge clk);
    while (gaps_on && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) check("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    m_total = m_total + 64'(data);
    m_n++;
    if (last) begin
      e_total = m_total;
      e_n     = m_n;
      m_total = '0;
      m_n     = 0;
    end
  endtask

  task automatic check_result(input bit hs);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("out_valid", 64'(out_valid), 64'd1);
    check("in_ready_hold", 64'(in_ready), 64'd0);
    check("sum16", 64'(out_sum), e_total & 64'hFFFF_FFFF_FFFF);
    check("count16", 64'(out_count), 64'(e_n));
    check("ovf16", 64'(out_ovf), 64'((e_total >> 48) != 0));
    check("sum2", 64'(out_sum2), e_total & 64'h3_FFFF_FFFF);
    check("count2", 64'(out_count2), 64'(e_n));
    check("ovf2", 64'(out_ovf2), 64'((e_total >> 34) != 0));
    if (hs) begin
      @(negedge clk);
      check("valid_drop", 64'(out_valid), 64'd0);
      check("ready_back", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    m_total = '0; m_n = 0; e_total = '0; e_n = 0; gaps_on = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(in_ready), 64'd1);

    // 1 + 2 + 3 with the consumer already ready
    out_ready = 1'b1;
    drive_beat(32'd1, 1'b0);
    drive_beat(32'd2, 1'b0);
    drive_beat(32'd3, 1'b1);
    check_result(1'b1);

    // carry out of the low word
    drive_beat(32'hFFFF_FFFF, 1'b0);
    drive_beat(32'h0000_0001, 1'b1);
    check_result(1'b1);

    // five all-ones beats: upper register wraps in the HI_W=2 instance
    for (int i = 0; i < 5; i++) drive_beat(32'hFFFF_FFFF, i == 4);
    check_result(1'b1);

    // backpressure on the result port
    out_ready = 1'b0;
    drive_beat(32'h1234_5678, 1'b0);
    drive_beat(32'h9ABC_DEF0, 1'b1);
    check_result(1'b0);
    held_sum = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA5;
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_sum", 64'(out_sum), 64'(held_sum));
      check("bp_count", 64'(out_count), 64'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    drive_beat(32'h10, 1'b1);
    check_result(1'b1);

    // single beat, then a gapped 4-beat packet
    drive_beat(32'hDEAD_BEEF, 1'b1);
    check_result(1'b1);
    gaps_on = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(32'h11, i == 3);
    check_result(1'b1);

    // random packets with gaps
    for (int p = 0; p < 6; p++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) drive_beat($urandom, i == len - 1);
      check_result(1'b1);
    end
    gaps_on = 1'b0;

    // reset in the middle of a packet aborts it
    drive_beat(32'h55, 1'b0);
    drive_beat(32'h66, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(out_sum), 64'd0);
    check("mid_rst_count", 64'(out_count), 64'd0);
    check("mid_rst_ovf", 64'(out_ovf), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    m_total = '0;
    m_n     = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(32'd7, 1'b0);
    drive_beat(32'd8, 1'b1);
    check_result(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
